// File: rtl/bt_msg_pkg.sv
// Shared types and constants for the Bluetooth message arbiter: FSM state
// encoding, source indices, terminator, and the message text table.
// Optional feature macro used by the block: BT_DROP_CNT_EN.
package bt_msg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } bt_state_e;

    localparam logic [7:0] TERM_CHAR = 8'h23;

    localparam int SRC_FAULT = 0;
    localparam int SRC_PICK  = 1;
    localparam int SRC_END   = 2;

    localparam int LEN_FAULT = 10;
    localparam int LEN_PICK  = 5;
    localparam int LEN_END   = 5;

    localparam logic [8*LEN_FAULT-1:0] MSG_FAULT = "FIM-CSU1-#";
    localparam logic [8*LEN_PICK-1:0]  MSG_PICK  = "PBM-#";
    localparam logic [8*LEN_END-1:0]   MSG_END   = "END-#";

    // Character idx of message src; positions past the text read as 0 padding.
    function automatic logic [7:0] rom_char(input int src, input int idx);
        logic [7:0] c;
        c = 8'h00;
        case (src)
            SRC_FAULT: if (idx < LEN_FAULT) c = MSG_FAULT[8*(LEN_FAULT-1-idx) +: 8];
            SRC_PICK:  if (idx < LEN_PICK)  c = MSG_PICK[8*(LEN_PICK-1-idx) +: 8];
            SRC_END:   if (idx < LEN_END)   c = MSG_END[8*(LEN_END-1-idx) +: 8];
            default:   c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bt_msg_arbiter_if.sv
// Request/UART-TX bundle of the message arbiter.
// Handshake: a character moves on a cycle where tx_valid && tx_ready; while
// tx_valid is high and tx_ready low, tx_data holds and tx_valid stays high.
// drop_cnt exists only when BT_DROP_CNT_EN is defined.
interface bt_msg_arbiter_if #(
    parameter int N_REQ = 3
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [GW-1:0]    grant_id;
    logic             msg_done;
`ifdef BT_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    modport master (
        input  req,
        input  tx_ready,
        output tx_data,
        output tx_valid,
        output busy,
        output grant_id,
        output msg_done
`ifdef BT_DROP_CNT_EN
        , output drop_cnt
`endif
    );

    modport slave (
        output req,
        output tx_ready,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  grant_id,
        input  msg_done
`ifdef BT_DROP_CNT_EN
        , input drop_cnt
`endif
    );

endinterface

// File: rtl/bt_msg_rom.sv
// Synchronous-read message ROM addressed by {src, char_idx}; the output
// register only loads when enabled, so the character holds between reads.
module bt_msg_rom
    import bt_msg_pkg::*;
#(
    parameter int SW = 2,
    parameter int IW = 4
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [SW+IW-1:0] i_addr,
    output logic [7:0]       o_data
);

    logic [7:0]    r_data;
    logic [SW-1:0] w_src;
    logic [IW-1:0] w_idx;

    assign w_src = i_addr[SW+IW-1:IW];
    assign w_idx = i_addr[IW-1:0];

    // Registered read of the addressed character
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 8'h00;
        end else if (i_en) begin
            r_data <= rom_char(int'(w_src), int'(w_idx));
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/bt_msg_arbiter.sv
// Round-robin owner of the Bluetooth UART TX: latches one-cycle requests in a
// pending register, grants one source at a time and streams its '#'-terminated
// message from the ROM. Optional duplicate-drop counter: BT_DROP_CNT_EN.
module bt_msg_arbiter
    import bt_msg_pkg::*;
#(
    parameter int         N_REQ       = 3,
    parameter int         MSG_MAX_LEN = 16,
    parameter logic [7:0] TERM_CHAR   = 8'h23
) (
    input  logic            clk_50M,
    input  logic            rst_n,
    bt_msg_arbiter_if.master bt,
    output bt_state_e       o_dbg_state
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int IW = (MSG_MAX_LEN > 1) ? $clog2(MSG_MAX_LEN) : 1;

    bt_state_e        r_state;
    bt_state_e        w_state_nxt;
    logic [N_REQ-1:0] r_pend;
    logic [N_REQ-1:0] w_clr;
    logic [GW-1:0]    r_grant_id;
    logic [GW-1:0]    r_last_grant;
    logic [IW-1:0]    r_char_idx;
    logic             r_msg_done;
    logic [7:0]       w_rom_q;
    logic             w_any;
    logic [GW-1:0]    w_sel;
    int               w_idx;
    logic             w_grant;
    logic             w_rom_en;
    logic             w_next_char;
    logic             w_finish;

    // Round-robin pick: first pending source after the last one served
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_last_grant) + 1 + k) % N_REQ;
            if (!w_any && r_pend[w_idx]) begin
                w_any = 1'b1;
                w_sel = GW'(w_idx);
            end
        end
    end

    // State register
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_rom_en    = 1'b0;
        w_next_char = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_rom_en    = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (bt.tx_ready) begin
                    // The length guard stops a message that lost its terminator
                    if (w_rom_q == TERM_CHAR || r_char_idx == IW'(MSG_MAX_LEN - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_next_char = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear mask for the source being granted this cycle
    always_comb begin
        w_clr = '0;
        if (w_grant) w_clr[w_sel] = 1'b1;
    end

    // Pending bits: a request arriving on the grant cycle re-queues the source
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | bt.req;
        end
    end

    // Grant bookkeeping, character cursor and the registered done pulse
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id   <= '0;
            r_last_grant <= GW'(N_REQ - 1);
            r_char_idx   <= '0;
            r_msg_done   <= 1'b0;
        end else begin
            r_msg_done <= w_finish;
            if (w_grant) begin
                r_grant_id <= w_sel;
                r_char_idx <= '0;
            end else if (w_next_char) begin
                r_char_idx <= r_char_idx + IW'(1);
            end
            if (w_finish) r_last_grant <= r_grant_id;
        end
    end

    bt_msg_rom #(
        .SW (GW),
        .IW (IW)
    ) u_rom (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .i_en    (w_rom_en),
        .i_addr  ({r_grant_id, r_char_idx}),
        .o_data  (w_rom_q)
    );

`ifdef BT_DROP_CNT_EN
    logic [7:0]       r_drop_cnt;
    logic [N_REQ-1:0] w_dup;
    logic [9:0]       w_drop_sum;

    // Requests landing on an already pending, not-being-granted source
    always_comb begin
        w_dup      = bt.req & r_pend & ~w_clr;
        w_drop_sum = 10'(r_drop_cnt) + 10'($countones(w_dup));
    end

    // Saturating duplicate counter
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'h00;
        end else begin
            r_drop_cnt <= (w_drop_sum > 10'd255) ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign bt.drop_cnt = r_drop_cnt;
`endif

    assign bt.tx_valid  = (r_state == ST_SEND);
    assign bt.tx_data   = w_rom_q;
    assign bt.busy      = (r_state != ST_IDLE);
    assign bt.grant_id  = r_grant_id;
    assign bt.msg_done  = r_msg_done;
    assign o_dbg_state  = r_state;

endmodule
